// File: rtl/packet_source.sv
// Packet source driving a four-phase return-to-zero flit channel.
// Each packet is a head flit (destination + sequence number) followed by indexed body flits.
module packet_source #(
  parameter int ID           = 0,
  parameter int SIZE         = 8,
  parameter int DEST_BITS    = 3,
  parameter int DEST         = 0,
  parameter int PACKET_FLITS = 4,
  parameter int GAP          = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  output logic            ch_req,
  output logic [SIZE-1:0] ch_flit,
  input  logic            ch_ack,
  output logic            busy,
  output logic [15:0]     pkt_count
);

  localparam int IDX_W = $clog2(PACKET_FLITS) + 1;
  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(PACKET_FLITS - 1);
  localparam logic [GAP_W-1:0]     GAP_LOAD   = GAP_W'(GAP);
  localparam logic [DEST_BITS-1:0] DEST_FIELD = DEST_BITS'(DEST);

  if (PACKET_FLITS < 1 || DEST_BITS < 1 || DEST_BITS >= SIZE) begin : g_param_check
    $error("packet_source %0d: illegal parameter set", ID);
  end

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    RELEASE  = 2'd2,
    GAP_WAIT = 2'd3
  } state_t;

  state_t           state_r, state_nxt_s;
  logic             req_r, req_nxt_s;
  logic [SIZE-1:0]  flit_r, flit_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic [15:0]      cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0] idx_r, idx_nxt_s;
  logic [GAP_W-1:0] gap_r, gap_nxt_s;

  // Head flit: destination in the top bits, sequence number truncated below it.
  function automatic logic [SIZE-1:0] head_flit(input logic [15:0] seq);
    logic [SIZE-1:0] f;
    f = '0;
    for (int i = 0; i < SIZE - DEST_BITS && i < 16; i++) f[i] = seq[i];
    f[SIZE-1 -: DEST_BITS] = DEST_FIELD;
    return f;
  endfunction

  // Body flit: its own index, zero-extended or truncated to the flit width.
  function automatic logic [SIZE-1:0] body_flit(input logic [IDX_W-1:0] k);
    logic [SIZE-1:0] f;
    f = '0;
    for (int i = 0; i < IDX_W && i < SIZE; i++) f[i] = k[i];
    return f;
  endfunction

  // Next-state and next-output logic for the handshake FSM.
  always_comb begin
    state_nxt_s = state_r;
    req_nxt_s   = req_r;
    flit_nxt_s  = flit_r;
    busy_nxt_s  = busy_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    gap_nxt_s   = gap_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt_s = REQ;
          req_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b1;
          idx_nxt_s   = '0;
          flit_nxt_s  = head_flit(cnt_r);
        end else begin
          state_nxt_s = IDLE;
        end
      end
      REQ: begin
        if (ch_ack) begin
          state_nxt_s = RELEASE;
          req_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = REQ;
        end
      end
      RELEASE: begin
        if (!ch_ack) begin
          if (idx_r == LAST_IDX) begin
            cnt_nxt_s  = cnt_r + 16'd1;
            busy_nxt_s = 1'b0;
            idx_nxt_s  = '0;
            if (GAP == 0) begin
              state_nxt_s = IDLE;
              gap_nxt_s   = '0;
            end else begin
              state_nxt_s = GAP_WAIT;
              gap_nxt_s   = GAP_LOAD;
            end
          end else begin
            state_nxt_s = REQ;
            req_nxt_s   = 1'b1;
            idx_nxt_s   = idx_r + IDX_W'(1);
            flit_nxt_s  = body_flit(idx_r + IDX_W'(1));
          end
        end else begin
          state_nxt_s = RELEASE;
        end
      end
      GAP_WAIT: begin
        // Leave on the cycle the counter reaches zero, so the gap lasts GAP cycles.
        if (gap_r <= GAP_W'(1)) begin
          state_nxt_s = IDLE;
          gap_nxt_s   = '0;
        end else begin
          state_nxt_s = GAP_WAIT;
          gap_nxt_s   = gap_r - GAP_W'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        req_nxt_s   = 1'b0;
        busy_nxt_s  = 1'b0;
        idx_nxt_s   = '0;
        gap_nxt_s   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      req_r   <= 1'b0;
      flit_r  <= '0;
      busy_r  <= 1'b0;
      cnt_r   <= 16'd0;
      idx_r   <= '0;
      gap_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      req_r   <= req_nxt_s;
      flit_r  <= flit_nxt_s;
      busy_r  <= busy_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  assign ch_req    = req_r;
  assign ch_flit   = flit_r;
  assign busy      = busy_r;
  assign pkt_count = cnt_r;

endmodule

// File: tb/tb_packet_source.sv
// Directed bench for packet_source: default, DEST=5, and single-flit/no-gap instances.
module tb_packet_source;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       en0, en5, en1;
  logic       req0, req5, req1;
  logic [7:0] flit0, flit5, flit1;
  logic       busy0, busy5, busy1;
  logic [15:0] cnt0, cnt5, cnt1;
  logic       auto0, ack_man;
  logic       ack_auto = 1'b0;
  logic       ack5 = 1'b0;
  logic       ack0, ack1;

  int tests = 0;
  int fails = 0;

  // Receivers: ack one cycle after req, release one cycle after req drops.
  always @(posedge clk) begin
    ack_auto <= req0;
    ack5     <= req5;
  end
  assign ack0 = auto0 ? ack_auto : ack_man;
  assign ack1 = req1;

  packet_source u_def (
    .clk(clk), .reset(reset), .enable(en0), .ch_req(req0), .ch_flit(flit0),
    .ch_ack(ack0), .busy(busy0), .pkt_count(cnt0));

  packet_source #(.DEST(5)) u_d5 (
    .clk(clk), .reset(reset), .enable(en5), .ch_req(req5), .ch_flit(flit5),
    .ch_ack(ack5), .busy(busy5), .pkt_count(cnt5));

  packet_source #(.PACKET_FLITS(1), .GAP(0)) u_p1 (
    .clk(clk), .reset(reset), .enable(en1), .ch_req(req1), .ch_flit(flit1),
    .ch_ack(ack1), .busy(busy1), .pkt_count(cnt1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic req_of(input int u);
    case (u)
      0:       return req0;
      1:       return req5;
      default: return req1;
    endcase
  endfunction

  function automatic logic busy_of(input int u);
    case (u)
      0:       return busy0;
      1:       return busy5;
      default: return busy1;
    endcase
  endfunction

  // Bounded wait for req of unit u to reach lvl; a timeout shows up as a failed check.
  task automatic wait_req(input int u, input logic lvl, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (req_of(u) === lvl) seen = 1'b1;
    end
    check(tag, {31'd0, req_of(u)}, {31'd0, lvl});
  endtask

  task automatic wait_idle(input int u, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (busy_of(u) === 1'b0) seen = 1'b1;
    end
    check(tag, {31'd0, busy_of(u)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, observed running expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en0 = 1'b0; en5 = 1'b0; en1 = 1'b0;
    auto0 = 1'b0; ack_man = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req",   {31'd0, req0},  32'd0);
    check("rst_flit",  {24'd0, flit0}, 32'd0);
    check("rst_busy",  {31'd0, busy0}, 32'd0);
    check("rst_count", {16'd0, cnt0},  32'd0);

    // First packet with continuous enable: flits 0..3, then count 1, gap, head seq 1.
    reset = 1'b0; auto0 = 1'b1; en0 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_req(0, 1'b1, "p0_rise");
      check("p0_flit", {24'd0, flit0}, 32'(k));
      wait_req(0, 1'b0, "p0_fall");
    end
    wait_idle(0, "p0_done");
    check("p0_count", {16'd0, cnt0}, 32'd1);
    @(negedge clk); check("gap1_req", {31'd0, req0}, 32'd0);
    @(negedge clk); check("gap2_req", {31'd0, req0}, 32'd0);
    @(negedge clk); check("head2_req", {31'd0, req0}, 32'd1);
    check("head2_flit", {24'd0, flit0}, 32'h01);

    // Enable drops mid-packet: the remaining flits still go out, then the block idles.
    en0 = 1'b0;
    wait_req(0, 1'b0, "p1_fall0");
    for (int k = 1; k < 4; k++) begin
      wait_req(0, 1'b1, "p1_rise");
      check("p1_flit", {24'd0, flit0}, 32'(k));
      wait_req(0, 1'b0, "p1_fall");
    end
    wait_idle(0, "p1_done");
    check("p1_count", {16'd0, cnt0}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stay_idle", {30'd0, req0, busy0}, 32'd0);
    end

    // Stalled ack holds req and flit; ack held high in RELEASE is ignored.
    auto0 = 1'b0; ack_man = 1'b0; en0 = 1'b1;
    wait_req(0, 1'b1, "p2_rise");
    en0 = 1'b0;
    check("p2_head", {24'd0, flit0}, 32'h02);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_hold", {23'd0, req0, flit0}, {23'd0, 1'b1, 8'h02});
    end
    ack_man = 1'b1;
    @(negedge clk); check("ack_drop", {31'd0, req0}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("release_hold", {23'd0, req0, flit0}, {23'd0, 1'b0, 8'h02});
    end
    ack_man = 1'b0;
    @(negedge clk); check("p2_body1", {23'd0, req0, flit0}, {23'd0, 1'b1, 8'h01});

    // Reset during RELEASE of flit 2 discards the packet; the next head uses seq 0.
    auto0 = 1'b1;
    wait_req(0, 1'b0, "p2_fall1");
    wait_req(0, 1'b1, "p2_rise2");
    check("p2_body2", {24'd0, flit0}, 32'h02);
    wait_req(0, 1'b0, "p2_fall2");
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_req",   {31'd0, req0}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy0}, 32'd0);
    check("mid_rst_count", {16'd0, cnt0}, 32'd0);
    reset = 1'b0; en0 = 1'b1;
    wait_req(0, 1'b1, "post_rst_rise");
    en0 = 1'b0;
    check("post_rst_head", {24'd0, flit0}, 32'h00);
    wait_idle(0, "post_rst_done");

    // DEST=5: head is 0xA0 | seq for seq 0..3.
    en5 = 1'b1;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) begin
        wait_req(1, 1'b1, "d5_rise");
        check(k == 0 ? "d5_head" : "d5_body", {24'd0, flit5},
              (k == 0) ? (32'hA0 | 32'(p)) : 32'(k));
        wait_req(1, 1'b0, "d5_fall");
      end
    end
    en5 = 1'b0;
    wait_idle(1, "d5_done");
    check("d5_count", {16'd0, cnt5}, 32'd4);

    // Single-flit packets, no gap, zero-delay ack: one head every 3 cycles.
    @(negedge clk);
    en1 = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      check("p1f_head", {23'd0, req1, flit1}, {23'd0, 1'b1, 8'(p)});
      @(negedge clk);
      check("p1f_rel", {31'd0, req1}, 32'd0);
      @(negedge clk);
      check("p1f_idle", {14'd0, req1, busy1, cnt1}, {14'd0, 1'b0, 1'b0, 16'(p + 1)});
    end
    en1 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/packet_source.md
PACKET_SOURCE -- requirements
Module: packet_source

Interface
REQ-001 Parameter ID, default 0: source identifier, used only in debug messages.
REQ-002 Parameter SIZE, default 8: flit width in bits.
REQ-003 Parameter DEST_BITS, default 3: width of the destination field in the head flit; DEST_BITS < SIZE.
REQ-004 Parameter DEST, default 0: destination address placed in every head flit.
REQ-005 Parameter PACKET_FLITS, default 4: flits per packet, head included; must be >= 1.
REQ-006 Parameter GAP, default 2: idle cycles between the end of one packet and the start of the next; 0 is legal.
REQ-007 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-008 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-009 Port enable, input, 1 bit: when high, the block may start a new packet.
REQ-010 Port ch_req, output, 1 bit: channel request, registered.
REQ-011 Port ch_flit, output, SIZE bits: channel flit, registered.
REQ-012 Port ch_ack, input, 1 bit: channel acknowledge from the receiver.
REQ-013 Port busy, output, 1 bit: high while a packet is in flight (head request issued to last release completed).
REQ-014 Port pkt_count, output, 16 bits: number of completed packets, wraps modulo 2^16.

Function
REQ-015 Channel protocol shall be four-phase return-to-zero: raise ch_req with ch_flit stable -> wait ch_ack=1 -> drop ch_req -> wait ch_ack=0.
REQ-016 ch_flit shall change only on an edge where ch_req goes 0->1 and shall hold until the next such edge.
REQ-017 FSM states shall be IDLE, REQ, RELEASE and GAP_WAIT.
REQ-018 IDLE: if enable=1 at an edge, load the head flit, set ch_req=1 and busy=1, and go to REQ; otherwise stay in IDLE.
REQ-019 REQ: ch_req=1; on an edge with ch_ack=1, set ch_req=0 and go to RELEASE; otherwise hold.
REQ-020 RELEASE: ch_req=0; on an edge with ch_ack=0, the next state depends on the flit just sent.
REQ-021 In RELEASE, if the flit just sent was not the last, load the next flit, set ch_req=1 and go to REQ.
REQ-022 In RELEASE, if the flit just sent was the last, increment pkt_count, clear busy, load the gap counter with GAP and go to GAP_WAIT; with GAP=0, go directly to IDLE.
REQ-023 GAP_WAIT: decrement the gap counter each cycle; when it reaches 0, go to IDLE. enable is ignored in this state.
REQ-024 With an ack that responds in zero cycles, throughput shall be one flit per 2 cycles and head latency from enable shall be 1 cycle.
REQ-025 Head flit: ch_flit[SIZE-1:SIZE-DEST_BITS] = DEST[DEST_BITS-1:0]; low SIZE-DEST_BITS bits = pkt_count truncated.
REQ-026 Body flit k (1..PACKET_FLITS-1) shall be k, zero-extended or truncated to SIZE bits.
REQ-027 With PACKET_FLITS=1, the head is also the last flit.
REQ-028 enable deasserted mid-packet shall not abort the packet; the packet completes.
REQ-029 ch_ack changes in states other than the awaited ones shall be ignored; no spurious transfer.
REQ-030 The flit index counter shall be sized $clog2(PACKET_FLITS)+1 bits so it cannot wrap within a packet.
REQ-031 pkt_count 16'hFFFF + 1 shall become 0.

Reset
REQ-032 reset=1 at an edge shall force IDLE with ch_req=0, ch_flit=0, busy=0, pkt_count=0, flit index 0 and gap counter 0, regardless of state, including mid-packet.
REQ-033 A packet interrupted by reset shall not be counted or resumed; the first packet after reset uses sequence number 0.

Verification
REQ-034 Defaults, enable=1, receiver acks 1 cycle after req and releases 1 cycle after req drops -> flits 0x00, 0x01, 0x02, 0x03; pkt_count=1; 2 idle cycles; next head 0x01.
REQ-035 DEST=5, SIZE=8, DEST_BITS=3 -> head flit = 0xA0 | seq; verify for seq 0..3.
REQ-036 Stall ch_ack low for 20 cycles in REQ -> ch_req and ch_flit held constant throughout; no progress.
REQ-037 Assert reset during RELEASE of flit 2 -> next cycle ch_req=0, busy=0, pkt_count=0; after release, a fresh head with seq 0 is sent.
REQ-038 PACKET_FLITS=1, GAP=0, ack zero-delay -> one head flit every 3 cycles (REQ, RELEASE, IDLE); pkt_count increments per packet.
REQ-039 Drop enable after the head is acked -> the remaining 3 flits are sent, then the block stays in IDLE.
